// File: rtl/instr_mem_pipelined_pkg.sv
// Shared instruction-fetch types: the NOP encoding returned on faults and the
// payload record carried through the response pipeline.
package riscv_structures;

    localparam int IMEM_ADDR_W = 32;

    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0]            data;
        logic [IMEM_ADDR_W-1:0] addr;
        logic                   fault;
    } imem_rsp_t;

endpackage

// File: rtl/instr_mem_pipelined_stage.sv
// One delay slice of the fetch response pipeline: valid bit plus payload,
// frozen while en_i is low and emptied by clr_i.
module imem_pipe_stage
    import riscv_structures::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en_i,
    input  logic      clr_i,
    input  logic      valid_i,
    input  imem_rsp_t rsp_i,
    output logic      valid_o,
    output imem_rsp_t rsp_o
);

    logic      valid_q;
    imem_rsp_t rsp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            rsp_q   <= rsp_i;
        end
    end

    assign valid_o = valid_q;
    assign rsp_o   = rsp_q;

endmodule

// File: rtl/instr_mem_pipelined.sv
// Pipelined instruction memory: valid/ready fetch port, fixed LATENCY response
// pipeline with stall and flush, fault reporting and a run-time program load port.
module instr_mem_pipelined
    import riscv_structures::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [31:0]       mem_q [DEPTH];
    logic              stall;
    logic              accept;
    logic [ADDR_W-1:0] req_word;
    logic [ADDR_W-1:0] ld_word;
    logic              req_in_range;
    logic              req_fault;
    logic              ld_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              unused_ld_lsb;
    imem_rsp_t         fetch_rsp;

    logic              s1_valid_q, s1_valid_d;
    imem_rsp_t         s1_rsp_q, s1_rsp_d;

    logic              pl_valid [LATENCY];
    imem_rsp_t         pl_rsp   [LATENCY];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = INSTR_NOP;
    end

    assign stall     = rsp_valid & ~rsp_ready;
    assign req_ready = ~stall & ~ld_en & rst_n;
    assign accept    = req_valid & req_ready;

    // Index is forced to 0 when out of range so the array is never over-indexed;
    // the faulting payload substitutes the NOP anyway.
    assign req_word     = {2'b00, req_addr[ADDR_W-1:2]};
    assign req_in_range = (req_word < DEPTH_A);
    assign req_fault    = (req_addr[1:0] != 2'b00) || !req_in_range;
    assign rd_idx       = req_in_range ? req_word[IDX_W-1:0] : '0;

    assign ld_word       = {2'b00, ld_addr[ADDR_W-1:2]};
    assign ld_in_range   = (ld_word < DEPTH_A);
    assign wr_idx        = ld_in_range ? ld_word[IDX_W-1:0] : '0;
    assign unused_ld_lsb = ^ld_addr[1:0];

    always @(posedge clk) begin
        if (ld_en && ld_in_range) mem_q[wr_idx] <= ld_data;
    end

    always_comb begin
        fetch_rsp       = '0;
        fetch_rsp.data  = req_fault ? INSTR_NOP : mem_q[rd_idx];
        fetch_rsp.addr  = IMEM_ADDR_W'(req_addr);
        fetch_rsp.fault = req_fault;
    end

    // Stage 1 holds the storage read; a same-cycle acceptance survives a flush.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_rsp_d   = s1_rsp_q;
        if (flush || !stall) s1_valid_d = accept;
        if (accept)          s1_rsp_d   = fetch_rsp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_rsp_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rsp_q   <= s1_rsp_d;
        end
    end

    assign pl_valid[0] = s1_valid_q;
    assign pl_rsp[0]   = s1_rsp_q;

    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        imem_pipe_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (~stall),
            .clr_i   (flush),
            .valid_i (pl_valid[g-1]),
            .rsp_i   (pl_rsp[g-1]),
            .valid_o (pl_valid[g]),
            .rsp_o   (pl_rsp[g])
        );
    end

    assign rsp_valid = pl_valid[LATENCY-1];
    assign rsp_data  = pl_rsp[LATENCY-1].data;
    assign rsp_addr  = ADDR_W'(pl_rsp[LATENCY-1].addr);
    assign rsp_fault = pl_rsp[LATENCY-1].fault;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && accept)
            $display("%0t imem req addr=%h data=%h", $time, req_addr, fetch_rsp.data);
        if (rst_n && rsp_valid && rsp_ready)
            $display("%0t imem rsp addr=%h data=%h fault=%0b", $time, rsp_addr, rsp_data, rsp_fault);
    end
`endif

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Directed bench for instr_mem_pipelined: a LATENCY=2 and a LATENCY=3 instance
// share one stimulus stream; each scenario checks the instance it targets.
module tb_instr_mem_pipelined;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_ready;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic        r2_req_ready, r2_rsp_valid, r2_rsp_fault;
    logic [31:0] r2_rsp_data, r2_rsp_addr;
    logic        r3_req_ready, r3_rsp_valid, r3_rsp_fault;
    logic [31:0] r3_rsp_data, r3_rsp_addr;

    int n_cmp = 0;
    int n_err = 0;

    instr_mem_pipelined #(.ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(r2_req_ready), .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(r2_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(r2_rsp_data),
        .rsp_addr(r2_rsp_addr), .rsp_fault(r2_rsp_fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    instr_mem_pipelined #(.ADDR_W(32), .DEPTH(256), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(r3_req_ready), .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(r3_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(r3_rsp_data),
        .rsp_addr(r3_rsp_addr), .rsp_fault(r3_rsp_fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ld_t;

    vec_t vecs [8];
    ld_t  lds  [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        lds[0] = '{32'h0000_0000, 32'h0000_0513};
        lds[1] = '{32'h0000_0004, 32'h07B0_0593};
        lds[2] = '{32'h0000_0008, 32'h06b5_2c23};
        lds[3] = '{32'h0000_000C, 32'h0780_2503};
        lds[4] = '{32'h0000_003C, 32'h00c5_8533};

        vecs[0] = '{32'h0000_0000, 32'h0000_0513, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h07B0_0593, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h06b5_2c23, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'h0780_2503, 1'b0};
        vecs[4] = '{32'h0000_0006, 32'h0000_0013, 1'b1};
        vecs[5] = '{32'h0000_0400, 32'h0000_0013, 1'b1};
        vecs[6] = '{32'h0000_03FC, 32'h0000_0013, 1'b0};
        vecs[7] = '{32'h0000_03FD, 32'h0000_0013, 1'b1};

        req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // reset state
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rsp_valid", {31'b0, r2_rsp_valid}, 32'd0);
        chk("rst_rsp_data",  r2_rsp_data, 32'd0);
        chk("rst_rsp_addr",  r2_rsp_addr, 32'd0);
        chk("rst_rsp_fault", {31'b0, r2_rsp_fault}, 32'd0);
        chk("rst_req_ready", {31'b0, r2_req_ready}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", {31'b0, r2_req_ready}, 32'd1);
        tick();

        // program load; fetches are blocked while loading
        foreach (lds[i]) begin
            ld_en = 1'b1; ld_addr = lds[i].addr; ld_data = lds[i].data;
            req_valid = 1'b1; req_addr = 32'h0;
            #1;
            chk("ld_req_ready", {31'b0, r2_req_ready}, 32'd0);
            tick();
        end
        idle(3);
        chk("ld_no_accept", {31'b0, r2_rsp_valid}, 32'd0);

        // back-to-back fetch table, LATENCY=2
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                req_valid = 1'b1; req_addr = vecs[j].addr;
                #1;
                chk("tbl_req_ready", {31'b0, r2_req_ready}, 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            tick();
            if (j == 0) begin
                chk("tbl_latency_not1", {31'b0, r2_rsp_valid}, 32'd0);
            end else begin
                chk("tbl_rsp_valid", {31'b0, r2_rsp_valid}, 32'd1);
                chk("tbl_rsp_data",  r2_rsp_data, vecs[j-1].data);
                chk("tbl_rsp_addr",  r2_rsp_addr, vecs[j-1].addr);
                chk("tbl_rsp_fault", {31'b0, r2_rsp_fault}, {31'b0, vecs[j-1].fault});
            end
        end
        tick();
        chk("tbl_drained", {31'b0, r2_rsp_valid}, 32'd0);
        idle(4);

        // backpressure hold on dut2
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("bp_rsp_valid", {31'b0, r2_rsp_valid}, 32'd1);
            chk("bp_rsp_data",  r2_rsp_data, 32'h07B0_0593);
            chk("bp_req_ready", {31'b0, r2_req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_data", r2_rsp_data, 32'h07B0_0593);
        tick();
        chk("bp_consumed", {31'b0, r2_rsp_valid}, 32'd0);
        req_valid = 1'b1; req_addr = 32'h8;
        #1;
        chk("bp_next_ready", {31'b0, r2_req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        chk("bp_next_valid", {31'b0, r2_rsp_valid}, 32'd1);
        chk("bp_next_data",  r2_rsp_data, 32'h06b5_2c23);
        idle(4);

        // flush overrides a held response on dut2
        req_valid = 1'b1; req_addr = 32'hC;
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        tick();
        chk("fs_held", {31'b0, r2_rsp_valid}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fs_req_ready", {31'b0, r2_req_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fs_cleared", {31'b0, r2_rsp_valid}, 32'd0);
        idle(4);

        // flush with redirect request on dut3
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        chk("fl3_empty_e1", {31'b0, r3_rsp_valid}, 32'd0);
        req_addr = 32'h3C; flush = 1'b1;
        #1;
        chk("fl3_req_ready", {31'b0, r3_req_ready}, 32'd1);
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("fl3_no_old0", {31'b0, r3_rsp_valid}, 32'd0);
        tick();
        chk("fl3_no_old4", {31'b0, r3_rsp_valid}, 32'd0);
        tick();
        chk("fl3_valid", {31'b0, r3_rsp_valid}, 32'd1);
        chk("fl3_data",  r3_rsp_data, 32'h00c5_8533);
        chk("fl3_addr",  r3_rsp_addr, 32'h3C);
        chk("fl3_fault", {31'b0, r3_rsp_fault}, 32'd0);
        tick();
        chk("fl3_single", {31'b0, r3_rsp_valid}, 32'd0);
        idle(4);

        // load while a fetch of the same word is in flight
        req_valid = 1'b1; req_addr = 32'h40;
        tick();
        ld_en = 1'b1; ld_addr = 32'h40; ld_data = 32'h0000_8067;
        #1;
        chk("wr_req_ready2", {31'b0, r2_req_ready}, 32'd0);
        chk("wr_req_ready3", {31'b0, r3_req_ready}, 32'd0);
        tick();
        ld_en = 1'b0;
        chk("wr_inflight_valid", {31'b0, r2_rsp_valid}, 32'd1);
        chk("wr_inflight_old",   r2_rsp_data, 32'h0000_0013);
        chk("wr_inflight_addr",  r2_rsp_addr, 32'h40);
        tick();
        req_valid = 1'b0;
        chk("wr_blocked_fetch", {31'b0, r2_rsp_valid}, 32'd0);
        tick();
        chk("wr_new_valid", {31'b0, r2_rsp_valid}, 32'd1);
        chk("wr_new_data",  r2_rsp_data, 32'h0000_8067);
        idle(4);

        // out-of-range load is dropped, then reset with two responses in flight
        ld_en = 1'b1; ld_addr = 32'h400; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        chk("ar_pre_valid", {31'b0, r2_rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid2", {31'b0, r2_rsp_valid}, 32'd0);
        chk("ar_valid3", {31'b0, r3_rsp_valid}, 32'd0);
        chk("ar_data",   r2_rsp_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_lost_a", {31'b0, r2_rsp_valid}, 32'd0);
        tick();
        chk("ar_lost_b", {31'b0, r3_rsp_valid}, 32'd0);
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("ar_mem_valid", {31'b0, r2_rsp_valid}, 32'd1);
        chk("ar_mem_kept",  r2_rsp_data, 32'h0000_0513);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
